// File: rtl/qq_cmd_ctrl_if.sv
// Command, response and queue-side signal bundle for qq_cmd_ctrl.
// The key/value type is a parameter so this file does not depend on the
// queue package; users bind it to pq_pkg::kv_t.
interface qq_cmd_ctrl_if #(
    parameter type kv_t = logic [15:0]
) ();

    // Host command channel
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    kv_t        cmd_kv;

    // Host response channel
    logic       rsp_valid;
    logic       rsp_ready;
    kv_t        rsp_kv;
    logic       rsp_err;
    logic       rsp_tmo;

    // Queue first-node interface
    logic       q_enq;
    logic       q_deq;
    logic       q_repl;
    kv_t        q_kv;
    kv_t        q_head;
    logic       q_rdy;
    logic       q_full;
    logic       q_empty;

    // Host plus queue side: issues commands, consumes responses, reports status
    modport master (
        output cmd_valid, cmd_op, cmd_kv, rsp_ready,
        output q_head, q_rdy, q_full, q_empty,
        input  cmd_ready, rsp_valid, rsp_kv, rsp_err, rsp_tmo,
        input  q_enq, q_deq, q_repl, q_kv
    );

    // Controller side
    modport slave (
        input  cmd_valid, cmd_op, cmd_kv, rsp_ready,
        input  q_head, q_rdy, q_full, q_empty,
        output cmd_ready, rsp_valid, rsp_kv, rsp_err, rsp_tmo,
        output q_enq, q_deq, q_repl, q_kv
    );

endinterface

// File: rtl/qq_cmd_ctrl.sv
// QuickQueue host-side command initiator.
// Accepts one ENQ/DEQ/REPL command at a time, checks it against the queue
// status, issues a single-cycle pulse into the queue's first node, waits for
// the queue to settle and returns one response per command.

package pq_pkg;

    typedef struct packed {
        logic [7:0] key;
        logic [7:0] val;
    } kv_t;

    // Empty slot sentinel: largest key so it always sorts last
    localparam kv_t KV_EMPTY = '{key: 8'hFF, val: 8'h00};

    typedef enum logic [1:0] {
        OP_ENQ  = 2'b00,
        OP_DEQ  = 2'b01,
        OP_REPL = 2'b10,
        OP_NOP  = 2'b11
    } op_e;

endpackage

module qq_cmd_ctrl
    import pq_pkg::*;
#(
    parameter  int CAP = 8,
    parameter  int TMO = 64,
    localparam int CW  = $clog2(CAP + 1)
) (
    input  logic          clk,
    input  logic          rst,
    qq_cmd_ctrl_if.slave  bus,
    output logic [CW-1:0] occ,
    output logic          hang
);

    localparam int WW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e        r_state;
    state_e        w_next;

    // Latched command
    op_e           r_op;
    kv_t           r_kv;

    // Registered outputs
    logic          r_cmd_ready;
    kv_t           r_rsp_kv;
    logic          r_rsp_err;
    logic          r_rsp_tmo;
    logic [CW-1:0] r_occ;
    logic          r_hang;
    logic [WW-1:0] r_wdog;

    // Combinational helpers
    logic          w_accept;
    logic          w_reject;
    logic          w_tmo_hit;
    logic          w_timeout;
    logic          w_q_enq;
    logic          w_q_deq;
    logic          w_q_repl;
    kv_t           w_q_kv;
    kv_t           w_q_head;

    assign w_q_head  = bus.q_head;
    assign w_accept  = (r_state == S_IDLE) && r_cmd_ready && bus.cmd_valid;

    // Queue status, not the local occupancy, decides whether a command is legal
    assign w_reject  = ((r_op == OP_ENQ) && bus.q_full)
                     || (((r_op == OP_DEQ) || (r_op == OP_REPL)) && bus.q_empty)
                     || (r_op == OP_NOP);

    // Current CHECK/WAIT cycle is the TMO-th one counted since accept
    assign w_tmo_hit = (r_wdog == WW'(TMO - 1));

    // A ready queue wins over the watchdog in the same cycle
    assign w_timeout = (((r_state == S_CHECK) && !w_reject) || (r_state == S_WAIT))
                     && !bus.q_rdy && w_tmo_hit;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next unassigned
        // and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_reject)         w_next = S_RESP;
                else if (bus.q_rdy)   w_next = S_ISSUE;
                else if (w_tmo_hit)   w_next = S_RESP;
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.q_rdy || w_tmo_hit) w_next = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Queue pulses and data: only ever active in ISSUE, one pulse at a time
    always_comb begin
        w_q_enq  = 1'b0;
        w_q_deq  = 1'b0;
        w_q_repl = 1'b0;
        w_q_kv   = KV_EMPTY;
        if (r_state == S_ISSUE) begin
            case (r_op)
                OP_ENQ: begin
                    w_q_enq = 1'b1;
                    w_q_kv  = r_kv;
                end
                OP_DEQ: begin
                    w_q_deq = 1'b1;
                end
                OP_REPL: begin
                    w_q_repl = 1'b1;
                    w_q_kv   = r_kv;
                end
                default: begin
                end
            endcase
        end
    end

    // Command latch on accept
    always_ff @(posedge clk) begin
        // NOTE: the latched command is only read after an accept has loaded
        // it, so it carries no reset.
        if (w_accept) begin
            r_op <= op_e'(bus.cmd_op);
            r_kv <= bus.cmd_kv;
        end
    end

    // Command-ready flag: registered so it reads 0 straight out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_ready <= 1'b0;
        end else begin
            r_cmd_ready <= (w_next == S_IDLE);
        end
    end

    // Watchdog: cleared on entry to CHECK, counts every CHECK/WAIT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (w_accept) begin
            r_wdog <= '0;
        end else if ((r_state == S_CHECK) || (r_state == S_WAIT)) begin
            if (!w_tmo_hit) r_wdog <= r_wdog + 1'b1;
        end
    end

    // Response payload, held stable while RESP waits for rsp_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_kv  <= KV_EMPTY;
            r_rsp_err <= 1'b0;
            r_rsp_tmo <= 1'b0;
        end else if ((r_state == S_CHECK) && w_reject) begin
            r_rsp_kv  <= KV_EMPTY;
            r_rsp_err <= 1'b1;
            r_rsp_tmo <= 1'b0;
        end else if (r_state == S_ISSUE) begin
            // DEQ/REPL return the head as it was before the operation
            r_rsp_kv  <= (r_op == OP_ENQ) ? r_kv : w_q_head;
            r_rsp_err <= 1'b0;
            r_rsp_tmo <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_kv  <= KV_EMPTY;
            r_rsp_err <= 1'b1;
            r_rsp_tmo <= 1'b1;
        end
    end

    // Occupancy tracking (saturating) and sticky hang flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ  <= '0;
            r_hang <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                if ((r_op == OP_ENQ) && (r_occ != CW'(CAP))) begin
                    r_occ <= r_occ + 1'b1;
                end else if ((r_op == OP_DEQ) && (r_occ != '0)) begin
                    r_occ <= r_occ - 1'b1;
                end
            end
            // A timeout after ISSUE leaves occ as already updated
            if (w_timeout) r_hang <= 1'b1;
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_kv    = r_rsp_kv;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_tmo   = r_rsp_tmo;
    assign bus.q_enq     = w_q_enq;
    assign bus.q_deq     = w_q_deq;
    assign bus.q_repl    = w_q_repl;
    assign bus.q_kv      = w_q_kv;
    assign occ           = r_occ;
    assign hang          = r_hang;

endmodule

// File: doc/qq_cmd_ctrl.md
Name: qq_cmd_ctrl

Overview:
- Host-side command initiator for the QuickQueue priority-queue chain.
- Accepts ENQ/DEQ/REPL requests on a valid/ready command channel and sequences single-cycle enq/deq/repl pulses into the queue's first node, gated by the queue's rdy/full/empty status.
- Returns one response per command on a valid/ready response channel, carrying the dequeued/replaced head, an error flag and a watchdog indication.
- Sits between the scheduler/test host and the queue top.

Parameters:
- CAP, 8: queue capacity in entries; sizes the occupancy counter.
- TMO, 64: maximum cycles to wait for q_rdy after an issue pulse before a timeout is declared.
- CW, $clog2(CAP+1): occupancy counter width; derived, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  00 ENQ, 01 DEQ, 10 REPL, 11 NOP
- cmd_kv  in  $bits(kv_t)  key/value for ENQ/REPL (pq_pkg kv_t)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_kv  out  $bits(kv_t)  head returned (DEQ/REPL); echo of cmd_kv (ENQ); KV_EMPTY on error
- rsp_err  out  1  command rejected (full/empty/reserved) or timed out
- rsp_tmo  out  1  response is a timeout
- q_enq, q_deq, q_repl  out  1 each  one-cycle pulses to the queue
- q_kv  out  $bits(kv_t)  data to queue left input
- q_head  in  $bits(kv_t)  queue head (left output, smallest key)
- q_rdy, q_full, q_empty  in  1 each  queue status
- occ  out  CW  tracked occupancy
- hang  out  1  sticky; set on any timeout, cleared only by rst

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE; cmd_ready=0; rsp_valid=0; rsp_err=0; rsp_tmo=0; rsp_kv=KV_EMPTY; q_enq=q_deq=q_repl=0; q_kv=KV_EMPTY; occ=0; hang=0; watchdog=0. A reset mid-command abandons the command with no response.
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch op/kv and go to CHECK.
  - CHECK: 1 cycle. Error cases go directly to RESP with rsp_err=1, rsp_kv=KV_EMPTY, no pulse:
    - ENQ with q_full=1;
    - DEQ or REPL with q_empty=1;
    - NOP (op 11).
    - Otherwise go to ISSUE once q_rdy=1; stay in CHECK while q_rdy=0, with the watchdog counting.
  - ISSUE: exactly one cycle.
    - Assert the single matching pulse; q_kv=latched kv for ENQ/REPL, KV_EMPTY for DEQ.
    - Capture q_head into rsp_kv for DEQ/REPL (pre-operation head); capture latched kv for ENQ.
    - occ +1 on ENQ, -1 on DEQ, unchanged on REPL; saturates at CAP and 0.
    - Go to WAIT.
  - WAIT: hold pulses low. Go to RESP on the first cycle with q_rdy=1, no earlier than 1 cycle after ISSUE.
  - RESP: rsp_valid=1 with rsp_kv/rsp_err/rsp_tmo held stable until rsp_ready=1, then go to IDLE. cmd_ready=0 throughout.
- Watchdog:
  - Cleared on entry to CHECK; counts each cycle in CHECK/WAIT.
  - On reaching TMO, go to RESP with rsp_err=1, rsp_tmo=1, rsp_kv=KV_EMPTY; set hang.
  - occ is not rolled back if the timeout occurs after ISSUE.
- Handshake rules:
  - At most one command in flight; minimum 4 cycles per command (IDLE→CHECK→ISSUE→WAIT→RESP).
  - Responses are returned in command order.
  - Never more than one of q_enq/q_deq/q_repl high in a cycle; no pulses in any state except ISSUE.
  - cmd_valid while cmd_ready=0 is ignored (no buffering).
- Consistency: occ is informational only. The queue status signals are authoritative for accept/reject decisions.

Test Plan:
- Reset, then ENQ key=5, ENQ key=3, ENQ key=9 → three pulses on q_enq, rsp_err=0 each, occ=3; then DEQ → rsp_kv.key=3, occ=2.
- With q_empty=1, issue DEQ and REPL → rsp_err=1, rsp_kv=KV_EMPTY, no q_deq/q_repl pulse, occ stays 0.
- Fill until q_full=1, then ENQ → rsp_err=1, no q_enq pulse, occ unchanged at CAP.
- Queue holds {2,7}; REPL key=4 → q_repl pulse with q_kv.key=4, rsp_kv.key=2, occ=2.
- Hold q_rdy=0 after ISSUE for TMO cycles → rsp_err=1, rsp_tmo=1, hang=1; next command is still accepted; hang stays 1 until rst.
- Hold rsp_ready=0 for 10 cycles → rsp_valid and rsp_kv stable, cmd_ready=0, no queue pulses; assert rst during WAIT → all outputs at reset values on the next cycle.
